multi_channel_trigger_generator: RTL and testbench

Parametrised successor to the single-input rising-edge trigger pulser used by the ILA capture path. It synchronises NUM_CH asynchronous probe inputs and applies a per-channel edge/level mode and an enable mask. Matches are combined with AND/OR, and an arm/hold-off/post-trigger sequence is run. It drives the ILA capture controller: a one-cycle trigger pulse, a post-trigger capture window and a done flag.

---
 rtl/multi_channel_trigger_generator.sv | 134 +++++++++++++
 tb/tb_multi_channel_trigger_generator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_trigger_generator.sv
// Multi-channel ILA trigger: synchronised probes, per-channel edge/level match,
// AND/OR combine, and an arm / hold-off / hunt / post-trigger capture sequence.
module multi_channel_trigger_generator #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_W   = 8,
  parameter int unsigned POST_W      = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_in,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [2*NUM_CH-1:0]   edge_mode,
  input  logic                  combine_and,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [HOLDOFF_W-1:0]  holdoff,
  input  logic [POST_W-1:0]     post_count,
  output logic                  trigger,
  output logic                  capture_en,
  output logic                  armed,
  output logic                  done,
  output logic [NUM_CH-1:0]     trig_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HUNT,
    S_POST,
    S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_CH-1:0]     r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]     r_hist;
  logic [NUM_CH-1:0]     w_sync_out;
  logic [NUM_CH-1:0]     w_match;
  logic                  w_hit;
  logic [HOLDOFF_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic [POST_W-1:0]     r_post_cnt, w_post_cnt_nxt;
  logic                  r_trigger, w_trigger_nxt;
  logic [NUM_CH-1:0]     r_trig_ch, w_trig_ch_nxt;

  // Synchronisers and history run in every state, so edges outside HUNT are simply lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= ch_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_sync_out;
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (edge_mode[2*i +: 2])
        2'b00:   w_match[i] = w_sync_out[i] & ~r_hist[i];
        2'b01:   w_match[i] = ~w_sync_out[i] & r_hist[i];
        2'b10:   w_match[i] = w_sync_out[i] ^ r_hist[i];
        default: w_match[i] = w_sync_out[i];
      endcase
    end
  end

  // An empty mask must never hit, including in AND mode where the reduction alone would pass.
  assign w_hit = combine_and ? ((|ch_mask) && (&(w_match | ~ch_mask)))
                             : (|(w_match & ch_mask));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_post_cnt <= '0;
      r_trigger  <= 1'b0;
      r_trig_ch  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_post_cnt <= w_post_cnt_nxt;
      r_trigger  <= w_trigger_nxt;
      r_trig_ch  <= w_trig_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_post_cnt_nxt = r_post_cnt;
    w_trigger_nxt  = 1'b0;
    w_trig_ch_nxt  = r_trig_ch;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            w_hold_cnt_nxt = holdoff;
            w_state_nxt    = (holdoff == '0) ? S_HUNT : S_ARMED;
          end
        end
        S_ARMED: begin
          w_hold_cnt_nxt = r_hold_cnt - HOLDOFF_W'(1);
          if (r_hold_cnt <= HOLDOFF_W'(1)) w_state_nxt = S_HUNT;
        end
        S_HUNT: begin
          if (w_hit) begin
            w_trigger_nxt  = 1'b1;
            w_trig_ch_nxt  = w_match & ch_mask;
            w_post_cnt_nxt = post_count;
            w_state_nxt    = (post_count == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          w_post_cnt_nxt = r_post_cnt - POST_W'(1);
          if (r_post_cnt <= POST_W'(1)) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign trigger    = r_trigger;
  assign capture_en = (r_state == S_POST);
  assign armed      = (r_state == S_ARMED) || (r_state == S_HUNT);
  assign done       = (r_state == S_DONE);
  assign trig_ch    = r_trig_ch;

endmodule

// File: tb/tb_multi_channel_trigger_generator.sv
// Scoreboard bench for multi_channel_trigger_generator: each run's timeline is predicted
// from the recorded probe waveform and checked cycle by cycle by an independent monitor.
module tb_multi_channel_trigger_generator;

  localparam int NCH = 4;
  localparam int S   = 2;
  localparam int HW  = 8;
  localparam int PW  = 10;
  localparam int L   = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    ch_in = '0;
  logic [NCH-1:0]    ch_mask = '0;
  logic [2*NCH-1:0]  edge_mode = '0;
  logic              combine_and = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [HW-1:0]     holdoff = '0;
  logic [PW-1:0]     post_count = '0;
  logic              trigger, capture_en, armed, done;
  logic [NCH-1:0]    trig_ch;

  multi_channel_trigger_generator #(
    .NUM_CH(NCH), .SYNC_STAGES(S), .HOLDOFF_W(HW), .POST_W(PW)
  ) dut (
    .clock(clock), .reset(reset), .ch_in(ch_in), .ch_mask(ch_mask),
    .edge_mode(edge_mode), .combine_and(combine_and), .arm(arm), .abort(abort),
    .holdoff(holdoff), .post_count(post_count), .trigger(trigger),
    .capture_en(capture_en), .armed(armed), .done(done), .trig_ch(trig_ch)
  );

  always #5 clock = ~clock;

  typedef struct {
    int             cyc;
    logic           armed, cap, done, trig;
    logic [NCH-1:0] tch;
  } stat_t;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] tch;
  } trig_t;

  stat_t          sq[$];
  trig_t          tq[$];
  int             n_vec = 0;
  int             n_miss = 0;
  int             cyc = -1;
  int             p = 0;
  logic [NCH-1:0] in_rec [4096];
  logic [NCH-1:0] wv [L];
  logic [NCH-1:0] exp_tch = '0;

  // Index of the most recent rising clock edge since reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    stat_t e;
    trig_t tr;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      e = sq.pop_front();
      chk("armed",      armed,      e.armed);
      chk("capture_en", capture_en, e.cap);
      chk("done",       done,       e.done);
      chk("trigger",    trigger,    e.trig);
      chk("trig_ch",    trig_ch,    e.tch);
    end
    if (trigger === 1'b1) begin
      if (tq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_trigger: got trigger=1 at edge %0d, required no trigger", cyc);
      end else begin
        tr = tq.pop_front();
        chk("trig_edge", cyc, tr.cyc);
        chk("trig_vec",  trig_ch, tr.tch);
      end
    end
  end

  function automatic logic [NCH-1:0] get_in(int t);
    return (t < 0) ? '0 : in_rec[t];
  endfunction

  // Channel matches seen during the cycle after edge n: current synchronised sample
  // is the input taken at edge n-S+1, the previous one at edge n-S.
  function automatic logic [NCH-1:0] match_at(int n, logic [2*NCH-1:0] mode);
    logic [NCH-1:0] s, h, m;
    s = get_in(n - S + 1);
    h = get_in(n - S);
    m = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   m[i] = s[i] && !h[i];
        2'b01:   m[i] = !s[i] && h[i];
        2'b10:   m[i] = s[i] != h[i];
        default: m[i] = s[i];
      endcase
    end
    return m;
  endfunction

  function automatic bit hit_at(int n, logic [NCH-1:0] mask, logic [2*NCH-1:0] mode, bit comb);
    logic [NCH-1:0] mv;
    mv = match_at(n, mode) & mask;
    return comb ? (mask != 0 && mv == mask) : (mv != 0);
  endfunction

  // First edge-n in hunt (from arm edge a + hold-off) whose trigger edge precedes bound.
  function automatic int search(int a, int h, int bound, logic [NCH-1:0] mask,
                                logic [2*NCH-1:0] mode, bit comb);
    for (int n = a + h; n + 1 < bound && n + 1 <= a + L - 1; n++)
      if (hit_at(n, mask, mode, comb)) return n;
    return -1;
  endfunction

  task automatic do_run(int h, int pp, logic [NCH-1:0] mask, logic [2*NCH-1:0] mode, bit comb,
                        int ab_rel, int xa_rel, bit rand_xarm, int rst_rel);
    int a, n, b_abs, last, end_act, hi;
    stat_t e;
    trig_t tr;
    a = p;
    for (int r = 0; r < L; r++) in_rec[a + r] = wv[r];
    if (rst_rel >= 0) begin
      ab_rel = -1;
      n = search(a, h, a + rst_rel + 1, mask, mode, comb);
      last = rst_rel;
    end else begin
      if (ab_rel < 0) begin
        n = search(a, h, a + L + 1, mask, mode, comb);
        if (n < 0 || n + pp + 1 > a + L - 1) ab_rel = L - 1;
      end
      if (ab_rel >= 0) n = search(a, h, a + ab_rel, mask, mode, comb);
      last = L - 1;
    end
    b_abs = (ab_rel >= 0) ? a + ab_rel : a + L + 100;
    if (rand_xarm) begin
      end_act = (n >= 0) ? n + pp : b_abs - 1;
      if (b_abs - 1 < end_act) end_act = b_abs - 1;
      hi = ((end_act + 1 < b_abs) ? end_act + 1 : b_abs) - a;
      if (hi > L - 1) hi = L - 1;
      xa_rel = int'($urandom_range(hi, 1));
    end
    for (int t = a; t <= a + last; t++) begin
      e.cyc = t; e.armed = 0; e.cap = 0; e.done = 0; e.trig = 0;
      if (t >= b_abs)              ;
      else if (n < 0 || t <= n)    e.armed = 1;
      else if (t <= n + pp)        e.cap = 1;
      else                         e.done = 1;
      if (n >= 0 && t == n + 1) begin
        e.trig  = 1;
        exp_tch = match_at(n, mode) & mask;
        tr.cyc  = t;
        tr.tch  = exp_tch;
        tq.push_back(tr);
      end
      e.tch = exp_tch;
      sq.push_back(e);
    end
    ch_mask = mask; edge_mode = mode; combine_and = comb;
    holdoff = HW'(h); post_count = PW'(pp);
    for (int r = 0; r <= last; r++) begin
      ch_in = wv[r];
      arm   = (r == 0) || (r == xa_rel);
      abort = (r == ab_rel);
      @(posedge clock);
      #2;
      arm = 1'b0;
      abort = 1'b0;
    end
    if (rst_rel >= 0) begin
      reset = 1'b0;
      #1;
      chk("rst_trigger",    trigger,    1'b0);
      chk("rst_capture_en", capture_en, 1'b0);
      chk("rst_armed",      armed,      1'b0);
      chk("rst_done",       done,       1'b0);
      chk("rst_trig_ch",    trig_ch,    '0);
      sq.delete();
      tq.delete();
      exp_tch = '0;
      p = 0;
    end else begin
      p = a + L;
    end
  endtask

  task automatic set_wave(logic [NCH-1:0] v0, int r1, logic [NCH-1:0] v1, int r2, logic [NCH-1:0] v2);
    for (int r = 0; r < L; r++) wv[r] = (r < r1) ? v0 : ((r < r2) ? v1 : v2);
  endtask

  initial begin
    logic [NCH-1:0] v;
    int ab;
    repeat (3) @(posedge clock);
    #1;
    chk("init_trigger",    trigger,    1'b0);
    chk("init_capture_en", capture_en, 1'b0);
    chk("init_armed",      armed,      1'b0);
    chk("init_done",       done,       1'b0);
    chk("init_trig_ch",    trig_ch,    '0);
    @(negedge clock);
    reset = 1'b1;
    p = 0;

    // ch0 rising, OR, no hold-off, three-cycle capture window.
    set_wave(4'b0000, 3, 4'b0001, L, 4'b0001);
    do_run(0, 3, 4'b0001, 8'h00, 1'b0, -1, -1, 1'b0, -1);
    // Hold-off 5: early edge ignored, later edge triggers.
    for (int r = 0; r < L; r++) wv[r] = ((r >= 2 && r < 5) || r >= 8) ? 4'b0001 : 4'b0000;
    do_run(5, 2, 4'b0001, 8'h00, 1'b0, -1, -1, 1'b0, -1);
    // AND: ch0 level-high with ch1 falling, then ch0 low, then empty masks.
    set_wave(4'b0011, 6, 4'b0001, L, 4'b0001);
    do_run(0, 1, 4'b0011, 8'b0000_0111, 1'b1, -1, -1, 1'b0, -1);
    set_wave(4'b0010, 6, 4'b0000, L, 4'b0000);
    do_run(0, 1, 4'b0011, 8'b0000_0111, 1'b1, -1, -1, 1'b0, -1);
    for (int r = 0; r < L; r++) wv[r] = (r % 2 == 1) ? 4'hF : 4'h0;
    do_run(0, 1, 4'b0000, 8'hAA, 1'b0, -1, -1, 1'b0, -1);
    do_run(0, 1, 4'b0000, 8'hFF, 1'b1, -1, -1, 1'b0, -1);
    // Either-edge on ch2 with zero post count goes straight to DONE.
    set_wave(4'b0100, 6, 4'b0000, L, 4'b0000);
    do_run(4, 0, 4'b0100, 8'b0010_0000, 1'b0, -1, -1, 1'b0, -1);
    // Re-arm during POST ignored; abort while two POST cycles remain.
    set_wave(4'b0000, 3, 4'b0001, L, 4'b0001);
    do_run(0, 5, 4'b0001, 8'h00, 1'b0, 9, 6, 1'b0, -1);
    // Asynchronous reset mid-POST, then input already high at release.
    do_run(0, 6, 4'b0001, 8'h00, 1'b0, -1, -1, 1'b0, 7);
    ch_in = 4'b0001;
    @(negedge clock);
    reset = 1'b1;
    for (int r = 0; r < L; r++) wv[r] = 4'b0001;
    do_run(0, 2, 4'b0001, 8'h00, 1'b0, -1, -1, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      v = in_rec[p - 1];
      for (int r = 0; r < L; r++) begin
        for (int i = 0; i < NCH; i++)
          if ($urandom_range(5, 0) == 0) v[i] = ~v[i];
        wv[r] = v;
      end
      ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(L - 1, 1)) : -1;
      do_run(int'($urandom_range(8, 0)), int'($urandom_range(6, 0)), NCH'($urandom),
             (2*NCH)'($urandom), 1'($urandom_range(1, 0)), ab, -1,
             1'($urandom_range(1, 0)), -1);
    end

    @(negedge clock);
    #1;
    chk("status_drain",  sq.size(), 0);
    chk("trigger_drain", tq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
